pw_store_ctrl: RTL and testbench
================================

PW_STORE_CTRL -- requirements
Module: pw_store_ctrl

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the store readout.
REQ-002 Parameter DEPTH, default 5: accepted words needed before a readout is valid.
REQ-003 Parameter TIMEOUT, default 8: max cycles to wait for store_valid after a request.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  snoop of the store input beat.
REQ-007 in_channel  input  1  snoop channel; a word is accepted when in_valid && in_channel==0.
REQ-008 cli_req  input  NREQ  level request per client, held until its cli_ack.
REQ-009 cli_ack  output  NREQ  one-hot, one-cycle completion pulse to the granted client.
REQ-010 cli_err  output  1  one-cycle pulse coincident with cli_ack when the readout timed out.
REQ-011 cli_data  output  16  readout word; valid while cli_ack is nonzero.
REQ-012 req_valid  output  1  one-cycle request pulse to the password store.
REQ-013 store_valid  input  1  store output valid.
REQ-014 store_data  input  16  store output word.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 fill counter SHALL increment on each accepted word and saturate at DEPTH; in_channel==1 beats SHALL NOT count.
REQ-017 States SHALL be IDLE, ARB, ISSUE, WAIT, DONE.
REQ-018 IDLE->ARB when fill==DEPTH and any cli_req bit is high; otherwise remain in IDLE.
REQ-019 ARB SHALL select one requester round-robin, starting after the last granted index; after reset the search starts at index 0. The selection is registered, and ARB->ISSUE takes 1 cycle.
REQ-020 ISSUE SHALL assert req_valid for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-021 WAIT SHALL capture store_data into cli_data and go to DONE on the first cycle store_valid==1 after ISSUE.
REQ-022 In WAIT, if TIMEOUT cycles elapse without store_valid, the block SHALL go to DONE with cli_data=16'h0000 and cli_err=1.
REQ-023 DONE SHALL pulse cli_ack[selected] for one cycle, clear fill to 0, update the last-granted pointer, and return to IDLE.
REQ-024 Minimum latency from a qualifying cli_req to cli_ack SHALL be 4 cycles (IDLE, ARB, ISSUE, WAIT), given store_valid on the first WAIT cycle.
REQ-025 Accepted words arriving during ARB through DONE SHALL still count. A word accepted in the DONE cycle SHALL leave fill=1, because the clear-then-increment result is 1.
REQ-026 A requester that drops cli_req before cli_ack SHALL still receive the ack; dropping the request does not abort the transaction.
REQ-027 If several cli_req bits are high, exactly one SHALL be served per transaction. A requester still asserting SHALL wait for fill to reach DEPTH again.
REQ-028 At most one cli_ack bit SHALL be high in any cycle, and req_valid SHALL never be high outside ISSUE.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, fill=0, the last-granted pointer = NREQ-1 so the next search starts at index 0, and the timeout counter = 0.
REQ-030 On reset, all outputs SHALL be 0: req_valid, cli_ack, cli_err, cli_data, busy.
REQ-031 Reset asserted in any state SHALL abort the transaction with no ack issued; it takes effect on the next clock edge.

Structure
REQ-032 Package pw_pkg SHALL hold the state enum type, the default DEPTH, TIMEOUT and NREQ values, and the data width constant (16).
REQ-033 The round-robin selection SHALL be a sub-module rr_arb: inputs request vector, last-grant pointer, clk, reset; output a one-hot grant.
REQ-034 The fill and timeout counters SHALL be sized $clog2(DEPTH+1) and $clog2(TIMEOUT+1) bits.

Verification
REQ-035 Fill gating: 4 accepted words, cli_req=2'b01 -> no req_valid; the 5th word arrives -> req_valid 2 cycles later. With store_valid=1 and store_data=16'hA5A5 -> cli_ack=2'b01, cli_data=16'hA5A5.
REQ-036 Channel filter: 10 words with in_channel=1 and cli_req=2'b01 -> fill stays 0 and req_valid never asserts.
REQ-037 Round-robin: cli_req=2'b11 held high and 5 words refilled twice -> acks are 2'b01 then 2'b10; a third refill -> 2'b01.
REQ-038 Timeout: store_valid held 0 -> cli_ack and cli_err pulse exactly TIMEOUT+1 cycles after req_valid, with cli_data=0.
REQ-039 Reset mid-WAIT: reset asserted for 1 cycle -> no cli_ack, busy=0, fill=0; the next request needs 5 new words.
REQ-040 DONE-cycle word: an accepted word coinciding with cli_ack -> fill=1 afterwards; 4 more words re-arm the block.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared types and defaults for the password-store readout controller.
// Holds the FSM state encoding, default sizing and the data width.
package pw_pkg;

  localparam int NREQ_DEF    = 2;
  localparam int DEPTH_DEF   = 5;
  localparam int TIMEOUT_DEF = 8;
  localparam int DATA_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pw_store_ctrl_if.sv
// Client, snoop and store-side signals of pw_store_ctrl, grouped as one bundle.
// The slave modport is the controller's view; master is the environment's.
interface pw_store_ctrl_if #(
  parameter int NREQ = pw_pkg::NREQ_DEF
);
  import pw_pkg::*;

  logic              in_valid;
  logic              in_channel;
  logic [NREQ-1:0]   cli_req;
  logic [NREQ-1:0]   cli_ack;
  logic              cli_err;
  logic [DATA_W-1:0] cli_data;
  logic              req_valid;
  logic              store_valid;
  logic [DATA_W-1:0] store_data;
  logic              busy;

  modport master (
    output in_valid, in_channel, cli_req, store_valid, store_data,
    input  cli_ack, cli_err, cli_data, req_valid, busy
  );

  modport slave (
    input  in_valid, in_channel, cli_req, store_valid, store_data,
    output cli_ack, cli_err, cli_data, req_valid, busy
  );

endinterface

// File: rtl/rr_arb.sv
// Round-robin picker: searches from last_idx+1 upward and registers a one-hot grant.
// Grant is valid one cycle after the request vector is presented; no backpressure.
module rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = pw_pkg::idx_w(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [NREQ-1:0]  grant
);

  logic [NREQ-1:0] grant_d;
  logic [NREQ-1:0] grant_q;

  always_comb begin
    grant_d = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if ((grant_d == '0) && req[IDX_W'((int'(last_idx) + i) % NREQ)]) begin
        grant_d[IDX_W'((int'(last_idx) + i) % NREQ)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
    end else begin
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/pw_store_ctrl.sv
// Gates client reads of the password store on DEPTH accepted words, arbitrates clients round-robin.
// Request-to-ack is 4 cycles minimum; store_valid may stall WAIT up to TIMEOUT cycles before an error ack.
module pw_store_ctrl
  import pw_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  pw_store_ctrl_if.slave bus
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = idx_w(NREQ);

  state_e            state_d, state_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic [TMO_W-1:0]  tmo_d, tmo_q;
  logic [IDX_W-1:0]  last_d, last_q;
  logic [NREQ-1:0]   sel_d, sel_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              err_d, err_q;
  logic [NREQ-1:0]   arb_grant;
  logic              accept;

  assign accept = bus.in_valid && !bus.in_channel;

  rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.cli_req),
    .last_idx (last_q),
    .grant    (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    tmo_d   = tmo_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = err_q;

    // Clear happens before the increment so a word landing in DONE leaves fill at 1.
    if (state_q == ST_DONE) begin
      fill_d = '0;
    end
    if (accept && (fill_d != FILL_W'(DEPTH))) begin
      fill_d = fill_d + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if ((fill_q == FILL_W'(DEPTH)) && (|bus.cli_req)) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        sel_d   = arb_grant;
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.store_valid) begin
          data_d  = bus.store_data;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if ((tmo_q + 1'b1) == TMO_W'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        for (int i = 0; i < NREQ; i++) begin
          if (sel_q[i]) begin
            last_d = IDX_W'(i);
          end
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      tmo_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      tmo_q   <= tmo_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_valid = (state_q == ST_ISSUE);
  assign bus.cli_ack   = (state_q == ST_DONE) ? sel_q : '0;
  assign bus.cli_err   = (state_q == ST_DONE) && err_q;
  assign bus.cli_data  = (state_q == ST_DONE) ? data_q : '0;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pw_store_ctrl.sv
// Directed bench for pw_store_ctrl with DEPTH=5, TIMEOUT=8, NREQ=2.
// Inputs change 1ns after posedge; outputs are sampled at that same point.
module tb_pw_store_ctrl;

  localparam int NREQ    = 2;
  localparam int DEPTH   = 5;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic seen;
  int   n;

  always #5 clk = ~clk;

  pw_store_ctrl_if #(.NREQ(NREQ)) bus ();

  pw_store_ctrl #(
    .NREQ    (NREQ),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic ch);
    bus.in_valid   = 1'b1;
    bus.in_channel = ch;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_channel = 1'b0;
  endtask

  task automatic fill_words(input int cnt);
    for (int i = 0; i < cnt; i++) word(1'b0);
  endtask

  task automatic wait_ack(input string tag, input logic [31:0] exp_ack,
                          input logic [31:0] exp_err, input logic [31:0] exp_dat);
    int k = 0;
    while (bus.cli_ack == '0 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_ack"}, 32'(bus.cli_ack), exp_ack);
    chk({tag, "_err"}, 32'(bus.cli_err), exp_err);
    chk({tag, "_data"}, 32'(bus.cli_data), exp_dat);
  endtask

  task automatic wait_rv(input string tag);
    int k = 0;
    while (!bus.req_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_rv"}, 32'(bus.req_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_channel  = 1'b0;
    bus.cli_req     = '0;
    bus.store_valid = 1'b0;
    bus.store_data  = '0;
    reset           = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_cli_ack", 32'(bus.cli_ack), 32'd0);
    chk("rst_cli_err", 32'(bus.cli_err), 32'd0);
    chk("rst_cli_data", 32'(bus.cli_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fill", 32'(dut.fill_q), 32'd0);
    reset = 1'b0;
    tick();

    // Fill gating with exact timing; requester drops its request mid-transaction
    bus.cli_req     = 2'b01;
    bus.store_valid = 1'b1;
    bus.store_data  = 16'hA5A5;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word(1'b0);
      seen |= bus.req_valid | bus.busy;
    end
    repeat (3) begin
      tick();
      seen |= bus.req_valid | bus.busy;
    end
    chk("t1_no_rv_at_4", 32'(seen), 32'd0);
    chk("t1_fill4", 32'(dut.fill_q), 32'd4);
    word(1'b0);
    chk("t1_e0_rv", 32'(bus.req_valid), 32'd0);
    tick();
    chk("t1_e1_busy", 32'(bus.busy), 32'd1);
    chk("t1_e1_rv", 32'(bus.req_valid), 32'd0);
    tick();
    chk("t1_e2_rv", 32'(bus.req_valid), 32'd1);
    bus.cli_req = 2'b00;
    tick();
    chk("t1_e3_rv", 32'(bus.req_valid), 32'd0);
    chk("t1_e3_ack", 32'(bus.cli_ack), 32'd0);
    tick();
    chk("t1_e4_ack", 32'(bus.cli_ack), 32'd1);
    chk("t1_e4_data", 32'(bus.cli_data), 32'hA5A5);
    chk("t1_e4_err", 32'(bus.cli_err), 32'd0);
    tick();
    chk("t1_after_ack", 32'(bus.cli_ack), 32'd0);
    chk("t1_after_busy", 32'(bus.busy), 32'd0);
    chk("t1_after_fill", 32'(dut.fill_q), 32'd0);

    // Channel filter
    bus.cli_req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      word(1'b1);
      seen |= bus.req_valid | bus.busy;
    end
    repeat (5) begin
      tick();
      seen |= bus.req_valid | bus.busy;
    end
    chk("t2_no_rv", 32'(seen), 32'd0);
    chk("t2_fill", 32'(dut.fill_q), 32'd0);
    bus.cli_req = 2'b00;

    // Round-robin from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cli_req    = 2'b11;
    bus.store_data = 16'h1111;
    fill_words(5);
    wait_ack("rr1", 32'h1, 32'd0, 32'h1111);
    tick();
    repeat (4) tick();
    chk("rr_wait_refill", 32'(bus.busy), 32'd0);
    fill_words(5);
    wait_ack("rr2", 32'h2, 32'd0, 32'h1111);
    tick();
    fill_words(5);
    wait_ack("rr3", 32'h1, 32'd0, 32'h1111);
    tick();
    bus.cli_req = 2'b00;

    // Timeout
    bus.store_valid = 1'b0;
    bus.cli_req     = 2'b01;
    fill_words(5);
    wait_rv("to");
    n = 0;
    while (bus.cli_ack == '0 && n < 30) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("to_ack", 32'(bus.cli_ack), 32'h1);
    chk("to_err", 32'(bus.cli_err), 32'd1);
    chk("to_data", 32'(bus.cli_data), 32'd0);
    tick();
    chk("to_err_pulse", 32'(bus.cli_err), 32'd0);
    chk("to_ack_pulse", 32'(bus.cli_ack), 32'd0);
    bus.cli_req = 2'b00;

    // Reset in WAIT aborts the transaction
    bus.cli_req = 2'b01;
    fill_words(5);
    wait_rv("rw");
    tick();
    tick();
    chk("rw_busy_wait", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_ack", 32'(bus.cli_ack), 32'd0);
    chk("rw_fill", 32'(dut.fill_q), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= (bus.cli_ack != '0) | bus.req_valid;
    end
    chk("rw_no_ack", 32'(seen), 32'd0);
    bus.store_valid = 1'b1;
    bus.store_data  = 16'h1234;
    fill_words(4);
    seen = 1'b0;
    repeat (2) begin
      tick();
      seen |= bus.req_valid | bus.busy;
    end
    chk("rw_need5", 32'(seen), 32'd0);
    word(1'b0);
    wait_ack("rw_rearm", 32'h1, 32'd0, 32'h1234);
    tick();

    // Word accepted in the DONE cycle
    bus.store_data = 16'hBEEF;
    fill_words(5);
    wait_ack("dw", 32'h1, 32'd0, 32'hBEEF);
    word(1'b0);
    chk("dw_fill1", 32'(dut.fill_q), 32'd1);
    chk("dw_idle", 32'(bus.busy), 32'd0);
    fill_words(3);
    repeat (2) tick();
    chk("dw_fill4", 32'(dut.fill_q), 32'd4);
    chk("dw_not_armed", 32'(bus.busy), 32'd0);
    word(1'b0);
    wait_ack("dw_rearm", 32'h1, 32'd0, 32'hBEEF);
    tick();
    chk("dw_final_fill", 32'(dut.fill_q), 32'd0);
    bus.cli_req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
